pipe_reg_async_rst: RTL and testbench
=====================================

PIPE_REG_ASYNC_RST -- requirements
Module: pipe_reg_async_rst

Interface
REQ-001 SHALL have parameter WIDTH, default 8: data width in bits (>=1).
REQ-002 SHALL have parameter DEPTH, default 3: number of pipeline stages (>=1).
REQ-003 SHALL have parameter RESET_VAL, default 0: WIDTH-bit value loaded into every stage data register on reset or flush.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on posedge clk.
REQ-005 SHALL have port R  input  1  reset, asynchronous, active-high.
REQ-006 SHALL have port flush  input  1  synchronous clear of all stages.
REQ-007 SHALL have port in_valid  input  1  upstream data valid.
REQ-008 SHALL have port in_data  input  WIDTH  upstream data.
REQ-009 SHALL have port in_ready  output  1  block can accept in_data this cycle.
REQ-010 SHALL have port out_valid  output  1  last stage holds valid data.
REQ-011 SHALL have port out_data  output  WIDTH  last-stage data.
REQ-012 SHALL have port out_ready  input  1  downstream accepts out_data this cycle.
REQ-013 SHALL have port count  output  $clog2(DEPTH+1)  number of valid stages.

Function
REQ-014 SHALL hold per stage i (0..DEPTH-1) a valid bit v[i] and data register d[i]; stage 0 is input side, stage DEPTH-1 drives out_valid/out_data.
REQ-015 SHALL compute stage readiness combinationally: rdy[DEPTH-1] = !v[DEPTH-1] | out_ready; rdy[i] = !v[i] | rdy[i+1]; in_ready = rdy[0] & !flush.
REQ-016 SHALL on a clock edge with rdy[i] high load stage i from stage i-1 (stage 0 from in_valid/in_data); d[i] loads only when the incoming valid is 1, else d[i] holds.
REQ-017 SHALL hold v[i] and d[i] unchanged when rdy[i] is low (backpressure; out_data stable while out_valid & !out_ready).
REQ-018 SHALL give latency exactly DEPTH cycles from input handshake to out_valid with out_ready held high, and sustain one transfer per cycle.
REQ-019 SHALL accept a new input when full if out_ready is high in the same cycle (simultaneous push/pop, no bubble).
REQ-020 SHALL on flush high at a clock edge clear all v[i] to 0, set all d[i] to RESET_VAL, drop the in-flight input, and ignore out_ready; flush has priority over advance.
REQ-021 SHALL update count every edge: +1 on input handshake, -1 on output handshake, unchanged on both or neither, 0 after flush; count never exceeds DEPTH.
REQ-022 SHALL drive out_valid = v[DEPTH-1], out_data = d[DEPTH-1] directly from registers (no combinational input-to-output path except ready chain).
REQ-023 SHALL function for DEPTH=1 (single register stage with full-throughput ready).

Reset
REQ-024 SHALL on R high, independent of clk, immediately clear all v[i], set all d[i] to RESET_VAL, count to 0; outputs then: out_valid=0, out_data=RESET_VAL, count=0, in_ready=1 (if flush low).
REQ-025 SHALL use the bare signal R as the asynchronous reset condition in every sequential process (no reduction, comparison or other expression on R).
REQ-026 SHALL hold reset state while R is high; first handshake possible on first posedge clk after R falls.
REQ-027 SHALL discard all in-flight data when R asserts mid-transfer, including between clock edges.

Verification
REQ-028 Stream: DEPTH=3, out_ready=1, push 0x11,0x22,0x33 on consecutive cycles -> out_valid rises 3 cycles after first push, outputs 0x11,0x22,0x33 on consecutive cycles, count peaks at 3.
REQ-029 Backpressure: fill with 0xA1..0xA3, out_ready=0 -> in_ready=0, count=3, out_data stays 0xA1; raise out_ready with in_valid=1, data 0xA4 -> same-edge pop/push, count stays 3.
REQ-030 Flush: count=2, assert flush with in_valid=1 -> next edge count=0, out_valid=0, out_data=RESET_VAL, in_ready=0 during flush cycle.
REQ-031 Async reset: with count=3, pulse R between clock edges -> out_valid=0, count=0, out_data=RESET_VAL before next posedge clk.
REQ-032 DEPTH=1, RESET_VAL=0x5A: reset -> out_data=0x5A; push 0x07 with out_ready=1 every cycle -> 1-cycle latency, continuous throughput.

Source files
------------

// File: rtl/pipe_reg_async_rst.sv
// Elastic register pipeline of DEPTH stages with a valid/ready handshake,
// a synchronous flush and an asynchronous active-high reset R.
module pipe_reg_async_rst #(
    parameter int              WIDTH     = 8,
    parameter int              DEPTH     = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       R,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       in_ready,
    output logic                       out_valid,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] v_reg;
    logic [WIDTH-1:0] d_reg [DEPTH];
    logic [CW-1:0]    count_reg;

    logic [DEPTH-1:0] rdy;
    logic [DEPTH-1:0] v_in;
    logic [WIDTH-1:0] d_in [DEPTH];
    logic             push;
    logic             pop;

    // A stage may load when it is empty or everything downstream of it moves.
    always_comb begin
        rdy            = '0;
        rdy[DEPTH-1]   = !v_reg[DEPTH-1] | out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            rdy[i] = !v_reg[i] | rdy[i+1];
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage_in
            if (gi == 0) begin : g_first
                assign v_in[gi] = in_valid;
                assign d_in[gi] = in_data;
            end else begin : g_chain
                assign v_in[gi] = v_reg[gi-1];
                assign d_in[gi] = d_reg[gi-1];
            end
        end
    endgenerate

    assign in_ready  = rdy[0] & !flush;
    assign push      = in_valid & in_ready;
    assign pop       = v_reg[DEPTH-1] & out_ready;

    always_ff @(posedge clk or posedge R) begin
        if (R) begin
            v_reg     <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= RESET_VAL;
            end
        end else if (flush) begin
            v_reg     <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                d_reg[i] <= RESET_VAL;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (rdy[i]) begin
                    v_reg[i] <= v_in[i];
                    // Bubbles keep the old data so idle stages do not toggle.
                    if (v_in[i]) begin
                        d_reg[i] <= d_in[i];
                    end
                end
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign out_valid = v_reg[DEPTH-1];
    assign out_data  = d_reg[DEPTH-1];
    assign count     = count_reg;

endmodule

// File: tb/tb_pipe_reg_async_rst.sv
// Directed bench for pipe_reg_async_rst: a DEPTH=3 instance and a DEPTH=1
// instance, with expected output words queued at each input handshake.
module tb_pipe_reg_async_rst;

    logic       clk = 1'b0;
    logic       R;
    logic       flush;
    logic       b_flush;

    logic       a_in_valid;
    logic [7:0] a_in_data;
    logic       a_in_ready;
    logic       a_out_valid;
    logic [7:0] a_out_data;
    logic       a_out_ready;
    logic [1:0] a_count;

    logic       b_in_valid;
    logic [7:0] b_in_data;
    logic       b_in_ready;
    logic       b_out_valid;
    logic [7:0] b_out_data;
    logic       b_out_ready;
    logic [0:0] b_count;

    int tests = 0;
    int fails = 0;

    logic [7:0] a_q[$];
    logic [7:0] b_q[$];

    always #5 clk = ~clk;

    pipe_reg_async_rst #(.WIDTH(8), .DEPTH(3), .RESET_VAL(8'h00)) dut_a (
        .clk(clk), .R(R), .flush(flush),
        .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
        .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
        .count(a_count)
    );

    pipe_reg_async_rst #(.WIDTH(8), .DEPTH(1), .RESET_VAL(8'h5A)) dut_b (
        .clk(clk), .R(R), .flush(b_flush),
        .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
        .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
        .count(b_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with inputs already driven; scores
    // the handshakes of the coming rising edge, then returns at the next falling edge.
    task automatic tick();
        logic [7:0] exp;
        #1;
        if (a_in_valid && a_in_ready) a_q.push_back(a_in_data);
        if (a_out_valid && a_out_ready && !flush) begin
            check("a_out_expected", 32'(a_q.size() != 0), 32'd1);
            if (a_q.size() != 0) begin
                exp = a_q.pop_front();
                check("a_out_data", 32'(a_out_data), 32'(exp));
            end
        end
        if (flush) a_q.delete();
        if (b_in_valid && b_in_ready) b_q.push_back(b_in_data);
        if (b_out_valid && b_out_ready) begin
            check("b_out_expected", 32'(b_q.size() != 0), 32'd1);
            if (b_q.size() != 0) begin
                exp = b_q.pop_front();
                check("b_out_data", 32'(b_out_data), 32'(exp));
            end
        end
        $display("[TB] t=%0t a: iv=%0b id=%h ir=%0b ov=%0b od=%h or=%0b cnt=%0d | b: iv=%0b id=%h ir=%0b ov=%0b od=%h cnt=%0d",
                 $time, a_in_valid, a_in_data, a_in_ready, a_out_valid, a_out_data, a_out_ready, a_count,
                 b_in_valid, b_in_data, b_in_ready, b_out_valid, b_out_data, b_count);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        R           = 1'b1;
        flush       = 1'b0;
        b_flush     = 1'b0;
        a_in_valid  = 1'b0;
        a_in_data   = 8'h00;
        a_out_ready = 1'b1;
        b_in_valid  = 1'b0;
        b_in_data   = 8'h00;
        b_out_ready = 1'b1;

        // Reset state
        #2;
        check("rst_a_out_valid", 32'(a_out_valid), 32'd0);
        check("rst_a_out_data",  32'(a_out_data),  32'h00);
        check("rst_a_count",     32'(a_count),     32'd0);
        check("rst_a_in_ready",  32'(a_in_ready),  32'd1);
        check("rst_b_out_data",  32'(b_out_data),  32'h5A);
        check("rst_b_out_valid", 32'(b_out_valid), 32'd0);
        @(negedge clk);
        R = 1'b0;

        // Stream 0x11,0x22,0x33 with out_ready high
        a_in_valid = 1'b1; a_in_data = 8'h11; tick();
        a_in_data = 8'h22; tick();
        check("stream_ov_before_latency", 32'(a_out_valid), 32'd0);
        check("stream_count_2", 32'(a_count), 32'd2);
        a_in_data = 8'h33; tick();
        check("stream_ov_at_latency", 32'(a_out_valid), 32'd1);
        check("stream_first_data", 32'(a_out_data), 32'h11);
        check("stream_count_peak", 32'(a_count), 32'd3);
        a_in_valid = 1'b0;
        tick(); tick(); tick();
        check("stream_drained_ov", 32'(a_out_valid), 32'd0);
        check("stream_drained_count", 32'(a_count), 32'd0);

        // Backpressure: fill with A1..A3 while the sink stalls
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hA1; tick();
        a_in_data = 8'hA2; tick();
        a_in_data = 8'hA3; tick();
        a_in_data = 8'hA4;
        #1;
        check("bp_in_ready_full", 32'(a_in_ready), 32'd0);
        check("bp_count_full", 32'(a_count), 32'd3);
        check("bp_out_data", 32'(a_out_data), 32'hA1);
        tick();
        check("bp_out_data_held", 32'(a_out_data), 32'hA1);
        check("bp_count_held", 32'(a_count), 32'd3);
        a_out_ready = 1'b1;
        #1;
        check("bp_in_ready_on_pop", 32'(a_in_ready), 32'd1);
        tick();
        check("bp_count_push_pop", 32'(a_count), 32'd3);
        check("bp_out_data_next", 32'(a_out_data), 32'hA2);
        a_in_valid = 1'b0;
        tick(); tick(); tick();
        check("bp_drained_count", 32'(a_count), 32'd0);
        check("bp_queue_empty", 32'(a_q.size()), 32'd0);

        // Flush with two words in flight and an input offered
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hB1; tick();
        a_in_data = 8'hB2; tick();
        check("fl_count_2", 32'(a_count), 32'd2);
        flush = 1'b1; a_in_data = 8'hB3; a_out_ready = 1'b1;
        #1;
        check("fl_in_ready_low", 32'(a_in_ready), 32'd0);
        tick();
        flush = 1'b0; a_in_valid = 1'b0;
        #1;
        check("fl_count_0", 32'(a_count), 32'd0);
        check("fl_out_valid", 32'(a_out_valid), 32'd0);
        check("fl_out_data", 32'(a_out_data), 32'h00);
        a_in_valid = 1'b1; a_in_data = 8'hC1; tick();
        a_in_valid = 1'b0;
        tick(); tick(); tick();
        check("fl_recover_empty", 32'(a_q.size()), 32'd0);

        // Asynchronous reset pulse between edges with a full pipe
        a_out_ready = 1'b0;
        a_in_valid = 1'b1; a_in_data = 8'hD1; tick();
        a_in_data = 8'hD2; tick();
        a_in_data = 8'hD3; tick();
        check("ar_count_full", 32'(a_count), 32'd3);
        a_in_valid = 1'b0;
        #2;
        R = 1'b1;
        #1;
        check("ar_out_valid", 32'(a_out_valid), 32'd0);
        check("ar_count", 32'(a_count), 32'd0);
        check("ar_out_data", 32'(a_out_data), 32'h00);
        R = 1'b0;
        a_q.delete();
        a_out_ready = 1'b1;
        @(negedge clk);
        check("ar_stays_empty", 32'(a_out_valid), 32'd0);

        // DEPTH=1 instance: one-cycle latency at full throughput
        check("d1_reset_data", 32'(b_out_data), 32'h5A);
        b_in_valid = 1'b1; b_in_data = 8'h07;
        #1;
        check("d1_in_ready_0", 32'(b_in_ready), 32'd1);
        tick();
        check("d1_latency_valid", 32'(b_out_valid), 32'd1);
        check("d1_latency_data", 32'(b_out_data), 32'h07);
        for (int i = 0; i < 4; i++) begin
            b_in_data = 8'h08 + 8'(i);
            #1;
            check("d1_in_ready_stream", 32'(b_in_ready), 32'd1);
            tick();
            check("d1_count_stream", 32'(b_count), 32'd1);
        end
        b_out_ready = 1'b0; b_in_data = 8'h20;
        #1;
        check("d1_in_ready_full", 32'(b_in_ready), 32'd0);
        tick();
        check("d1_held_data", 32'(b_out_data), 32'h0B);
        b_in_valid = 1'b0; b_out_ready = 1'b1;
        tick();
        check("d1_drained_valid", 32'(b_out_valid), 32'd0);
        check("d1_drained_count", 32'(b_count), 32'd0);
        check("d1_queue_empty", 32'(b_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
